// File: rtl/adc_frontend_ctrl.sv
// adc_frontend_ctrl
// ADC capture front end: registers raw samples, converts offset-binary to
// two's complement, drives the differential ADC clock and the PGA gain,
// blanks the output stream for a settle window after every gain change,
// and tracks a sticky overrange flag and the peak sample magnitude.
//
// Handshake: there is no back-pressure. A sample leaves on o_data_out every
// clock; o_data_valid qualifies it (low while the PGA is settling) and the
// consumer must take or drop it on that same cycle.
module adc_frontend_ctrl #(
  parameter int DATA_W     = 12,
  parameter int GAIN_W     = 4,
  parameter int SETTLE_CYC = 16,
  parameter int TWOS_COMP  = 1,
  parameter int GAIN_RST   = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_adc_data,
  input  logic              i_adc_or,
  input  logic [GAIN_W-1:0] i_gain_req,
  input  logic              i_or_clr,
  input  logic              i_peak_clr,
  output logic              o_adc_clk_p,
  output logic              o_adc_clk_n,
  output logic [GAIN_W-1:0] o_gain_out,
  output logic [DATA_W-1:0] o_data_out,
  output logic              o_data_valid,
  output logic              o_gain_busy,
  output logic              o_or_flag,
  output logic [DATA_W-1:0] o_peak_mag
);

  localparam int                CNT_W      = $clog2(SETTLE_CYC) + 1;
  localparam logic [CNT_W-1:0]  L_CNT_INIT = CNT_W'(SETTLE_CYC - 1);
  localparam logic [GAIN_W-1:0] L_GAIN_RST = GAIN_W'(GAIN_RST);
  // Mid-scale raw code: the stage-1 register resets here so the empty
  // pipeline never looks like an out-of-range code.
  localparam logic [DATA_W-1:0] L_MID      = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SETTLE = 1'b1
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [GAIN_W-1:0]   r_g1;
  logic [GAIN_W-1:0]   r_g2;
  logic [GAIN_W-1:0]   r_gain;
  logic                r_busy;

  logic [DATA_W-1:0]   r_s1;
  logic                r_v1;
  logic                r_or1;
  logic [DATA_W-1:0]   r_data;
  logic                r_valid;
  logic                r_or_flag;
  logic [DATA_W-1:0]   r_peak;

  logic [DATA_W-1:0]   w_conv;
  logic [DATA_W-1:0]   w_sd;
  logic [DATA_W-1:0]   w_mag;
  logic                w_s1_oor;

  // Differential ADC clock straight from the sample clock, independent of reset.
  assign o_adc_clk_p = i_clk;
  assign o_adc_clk_n = ~i_clk;

  // Stage-1 sample converted for stage 2 (MSB flip when two's complement is selected).
  assign w_conv = (TWOS_COMP != 0) ? {~r_s1[DATA_W-1], r_s1[DATA_W-2:0]} : r_s1;

  // Raw code pinned at either rail counts as overrange.
  assign w_s1_oor = (&r_s1) | ~(|r_s1);

  // Signed view of the stage-2 sample; in pass-through mode the MSB flip
  // turns the offset-binary distance from mid-code into a signed value.
  assign w_sd  = (TWOS_COMP != 0) ? r_data : {~r_data[DATA_W-1], r_data[DATA_W-2:0]};
  // Absolute value; the most negative code negates to 2^(DATA_W-1) which
  // still fits as an unsigned DATA_W-bit number.
  assign w_mag = w_sd[DATA_W-1] ? (~w_sd + 1'b1) : w_sd;

  // Two-flop synchroniser for the asynchronous gain request.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_g1 <= L_GAIN_RST;
      r_g2 <= L_GAIN_RST;
    end else begin
      r_g1 <= i_gain_req;
      r_g2 <= r_g1;
    end
  end

  // Gain FSM: apply a new gain and (re)start the settle window, count it down, then go idle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_SETTLE;
      r_cnt   <= L_CNT_INIT;
      r_gain  <= L_GAIN_RST;
      r_busy  <= 1'b1;
    end else if (r_g2 != r_gain) begin
      r_gain  <= r_g2;
      r_cnt   <= L_CNT_INIT;
      r_state <= ST_SETTLE;
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        ST_SETTLE: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Stage 1: capture raw sample, validity (not settling) and overrange pin.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1  <= L_MID;
      r_v1  <= 1'b0;
      r_or1 <= 1'b0;
    end else begin
      r_s1  <= i_adc_data;
      r_v1  <= ~r_busy;
      r_or1 <= i_adc_or;
    end
  end

  // Stage 2: converted sample and its validity.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_data  <= w_conv;
      r_valid <= r_v1;
    end
  end

  // Sticky overrange flag; a new overrange beats a same-cycle clear.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_or_flag <= 1'b0;
    end else if (r_or1 || w_s1_oor) begin
      r_or_flag <= 1'b1;
    end else if (i_or_clr) begin
      r_or_flag <= 1'b0;
    end
  end

  // Peak magnitude of valid samples; a clear restarts from the current valid sample.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_peak <= '0;
    end else if (i_peak_clr) begin
      r_peak <= r_valid ? w_mag : '0;
    end else if (r_valid && (w_mag > r_peak)) begin
      r_peak <= w_mag;
    end
  end

  assign o_gain_out   = r_gain;
  assign o_gain_busy  = r_busy;
  assign o_data_out   = r_data;
  assign o_data_valid = r_valid;
  assign o_or_flag    = r_or_flag;
  assign o_peak_mag   = r_peak;

endmodule

// File: tb/tb_adc_frontend_ctrl.sv
// tb_adc_frontend_ctrl
// Randomised bench for adc_frontend_ctrl with a cycle-indexed reference
// model: expected values come from input histories and the block's rules
// (sample latency, gain latency, settle length in cycles since last change).
module tb_adc_frontend_ctrl;

  localparam int DATA_W     = 12;
  localparam int GAIN_W     = 4;
  localparam int SETTLE_CYC = 16;
  localparam int GAIN_RST   = 0;
  localparam int MID        = 1 << (DATA_W - 1);
  localparam int FULL       = (1 << DATA_W) - 1;
  localparam int MAXC       = 4096;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] adc_data = '0;
  logic              adc_or = 1'b0;
  logic [GAIN_W-1:0] gain_req = '0;
  logic              or_clr = 1'b0;
  logic              peak_clr = 1'b0;
  logic              adc_clk_p;
  logic              adc_clk_n;
  logic [GAIN_W-1:0] gain_out;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              gain_busy;
  logic              or_flag;
  logic [DATA_W-1:0] peak_mag;

  always #5 clk = ~clk;

  adc_frontend_ctrl #(
    .DATA_W    (DATA_W),
    .GAIN_W    (GAIN_W),
    .SETTLE_CYC(SETTLE_CYC),
    .TWOS_COMP (1),
    .GAIN_RST  (GAIN_RST)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_adc_data  (adc_data),
    .i_adc_or    (adc_or),
    .i_gain_req  (gain_req),
    .i_or_clr    (or_clr),
    .i_peak_clr  (peak_clr),
    .o_adc_clk_p (adc_clk_p),
    .o_adc_clk_n (adc_clk_n),
    .o_gain_out  (gain_out),
    .o_data_out  (data_out),
    .o_data_valid(data_valid),
    .o_gain_busy (gain_busy),
    .o_or_flag   (or_flag),
    .o_peak_mag  (peak_mag)
  );

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] exp_q[$];

  int n;                 // rising edges since reset release
  int h_adc [MAXC];      // input values present at edge k
  bit h_or  [MAXC];
  int h_greq[MAXC];
  bit busy_h[MAXC];      // expected busy after edge k
  int m_gain;
  int m_last;            // edge of the last gain application (0 = reset release)
  bit m_valid;
  int m_mag;
  bit m_or;
  int m_peak;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h n=%0d t=%0t", tag, got, exp, n, $time);
    end
  endtask

  function automatic int rnd_adc();
    return int'($urandom_range(1, FULL - 1));
  endfunction

  // Rule-level model of one rising edge.
  task automatic model_step(input bit oclr, input bit pclr);
    int g_used;
    int d;
    // peak uses the sample that was on the output before this edge
    if (pclr) m_peak = m_valid ? m_mag : 0;
    else if (m_valid && (m_mag > m_peak)) m_peak = m_mag;
    // overrange: pin or rail code from the sample taken one edge earlier
    if (n >= 2 && (h_or[n-1] || h_adc[n-1] == 0 || h_adc[n-1] == FULL)) m_or = 1'b1;
    else if (oclr) m_or = 1'b0;
    // gain request reaches the FSM two edges after it was sampled
    g_used = (n >= 3) ? h_greq[n-2] : GAIN_RST;
    if (g_used != m_gain) begin
      m_gain = g_used;
      m_last = n;
    end
    busy_h[n] = (n - m_last) < SETTLE_CYC;
    m_valid = (n >= 2) && !busy_h[n-2];
    if (n >= 2) begin
      d = h_adc[n-1] - MID;
      m_mag = (d < 0) ? -d : d;
    end else begin
      m_mag = 0;
    end
  endtask

  task automatic compare_all();
    if (exp_q.size() == 2) check("data_out", 32'(data_out), 32'(exp_q.pop_front()));
    check("data_valid", 32'(data_valid), 32'(m_valid));
    check("gain_busy", 32'(gain_busy), 32'(busy_h[n]));
    check("gain_out", 32'(gain_out), 32'(m_gain));
    check("or_flag", 32'(or_flag), 32'(m_or));
    check("peak_mag", 32'(peak_mag), 32'(m_peak));
    check("adc_clk_p_low", 32'(adc_clk_p), 32'd0);
    check("adc_clk_n_high", 32'(adc_clk_n), 32'd1);
  endtask

  // ---------------- driver tasks ----------------
  task automatic run_cycle(input int adc, input bit aor, input int greq, input bit oclr, input bit pclr);
    int k;
    k = n + 1;
    adc_data = adc[DATA_W-1:0];
    adc_or   = aor;
    gain_req = greq[GAIN_W-1:0];
    or_clr   = oclr;
    peak_clr = pclr;
    h_adc[k]  = adc;
    h_or[k]   = aor;
    h_greq[k] = greq;
    exp_q.push_back(DATA_W'(adc - MID));
    @(posedge clk);
    n = k;
    model_step(oclr, pclr);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst      = 1'b1;
    adc_data = DATA_W'(MID);
    adc_or   = 1'b0;
    gain_req = GAIN_W'(GAIN_RST);
    or_clr   = 1'b0;
    peak_clr = 1'b0;
    #1;
    // asynchronous: values must already be back before any clock edge
    check("rst_gain_out", 32'(gain_out), 32'(GAIN_RST));
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_data_valid", 32'(data_valid), 32'd0);
    check("rst_or_flag", 32'(or_flag), 32'd0);
    check("rst_peak_mag", 32'(peak_mag), 32'd0);
    check("rst_gain_busy", 32'(gain_busy), 32'd1);
    @(posedge clk);
    #1;
    check("rst_adc_clk_p_high", 32'(adc_clk_p), 32'd1);
    check("rst_adc_clk_n_low", 32'(adc_clk_n), 32'd0);
    check("rst_hold_gain_busy", 32'(gain_busy), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    m_gain = GAIN_RST;
    m_last = 0;
    busy_h[0] = 1'b1;
    m_valid = 1'b0;
    m_mag = 0;
    m_or = 1'b0;
    m_peak = 0;
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt_busy;
    int cnt_inval;
    int gr;
    int a;

    do_reset();

    // idle after reset: blanking of SETTLE_CYC+2 samples
    for (int i = 0; i < 30; i++) run_cycle(rnd_adc(), 1'b0, 0, 1'b0, 1'b0);

    // directed codes: mid, mid-1, bottom rail
    run_cycle('h800, 1'b0, 0, 1'b0, 1'b0);
    run_cycle('h7FF, 1'b0, 0, 1'b0, 1'b0);
    run_cycle('h000, 1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) run_cycle(rnd_adc(), 1'b0, 0, 1'b0, 1'b0);
    check("peak_after_codes", 32'(peak_mag), 32'h800);
    check("or_after_zero_code", 32'(or_flag), 32'd1);
    run_cycle(rnd_adc(), 1'b0, 0, 1'b1, 1'b0);
    check("or_cleared", 32'(or_flag), 32'd0);

    // gain 0 -> 5 from idle: busy and blanking both exactly SETTLE_CYC
    cnt_busy = 0;
    cnt_inval = 0;
    for (int i = 0; i < 40; i++) begin
      run_cycle(rnd_adc(), 1'b0, 5, 1'b0, 1'b0);
      if (i == 1) check("gain_before_3rd_edge", 32'(gain_out), 32'd0);
      if (i == 2) check("gain_on_3rd_edge", 32'(gain_out), 32'd5);
      if (gain_busy) cnt_busy++;
      if (!data_valid) cnt_inval++;
    end
    check("busy_len_single", 32'(cnt_busy), 32'(SETTLE_CYC));
    check("blank_len_single", 32'(cnt_inval), 32'(SETTLE_CYC));

    // back to 0, then 0 -> 5 and 5 -> 7 eight cycles into the window
    for (int i = 0; i < 30; i++) run_cycle(rnd_adc(), 1'b0, 0, 1'b0, 1'b0);
    cnt_busy = 0;
    for (int i = 0; i < 50; i++) begin
      run_cycle(rnd_adc(), 1'b0, (i < 8) ? 5 : 7, 1'b0, 1'b0);
      if (gain_busy) cnt_busy++;
    end
    check("busy_len_restart", 32'(cnt_busy), 32'(8 + SETTLE_CYC));
    check("gain_after_restart", 32'(gain_out), 32'd7);

    // overrange pin pulse, clear, and clear coincident with new overrange
    run_cycle(rnd_adc(), 1'b1, 7, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) run_cycle(rnd_adc(), 1'b0, 7, 1'b0, 1'b0);
    check("or_sticky", 32'(or_flag), 32'd1);
    run_cycle(rnd_adc(), 1'b0, 7, 1'b1, 1'b0);
    run_cycle(rnd_adc(), 1'b0, 7, 1'b0, 1'b0);
    check("or_clr_alone", 32'(or_flag), 32'd0);
    run_cycle(rnd_adc(), 1'b1, 7, 1'b0, 1'b0);
    run_cycle(rnd_adc(), 1'b0, 7, 1'b1, 1'b0);
    check("or_set_beats_clr", 32'(or_flag), 32'd1);

    // peak clear while settling
    for (int i = 0; i < 5; i++) run_cycle(rnd_adc(), 1'b0, 9, 1'b0, 1'b0);
    run_cycle(rnd_adc(), 1'b0, 9, 1'b0, 1'b1);
    check("peak_clr_settle", 32'(peak_mag), 32'd0);
    for (int i = 0; i < 22; i++) run_cycle(rnd_adc(), 1'b0, 9, 1'b0, 1'b0);
    run_cycle(rnd_adc(), 1'b0, 9, 1'b0, 1'b1);

    // reset in the middle of a settle window
    for (int i = 0; i < 9; i++) run_cycle(rnd_adc(), 1'b0, 3, 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 30; i++) run_cycle(rnd_adc(), 1'b0, 0, 1'b0, 1'b0);

    // randomised soak
    gr = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) gr = int'($urandom_range(0, (1 << GAIN_W) - 1));
      a = rnd_adc();
      if ($urandom_range(0, 19) == 0) a = ($urandom_range(0, 1) == 0) ? 0 : FULL;
      run_cycle(a, ($urandom_range(0, 29) == 0), gr,
                ($urandom_range(0, 9) == 0), ($urandom_range(0, 24) == 0));
    end

    // ---------------- final report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/adc_frontend_ctrl.md
Name: adc_frontend_ctrl

Overview:
Parametrised successor to the single-channel ADC capture/gain block. It registers ADC samples and converts them from offset-binary to two's complement (selectable). It drives the differential ADC clock and the PGA gain bits. After every gain change it blanks the output for a programmable settle window, and it tracks sticky overrange and peak magnitude for AGC software. It sits between the ADC pins and the DSP chain.

Parameters:
DATA_W, 12, ADC sample width (bits)
GAIN_W, 4, PGA gain control width
SETTLE_CYC, 16, cycles data_valid is held low after a gain change or reset (must be >= 1)
TWOS_COMP, 1, 1 = invert sample MSB (offset-binary to two's complement); 0 = pass through unchanged
GAIN_RST, 0, gain_out value after reset

Ports:
clk  in  1  sample clock; also the source of the ADC clock
rst  in  1  asynchronous, active-high reset
adc_data  in  DATA_W  raw ADC output bus
adc_or  in  1  ADC overrange pin
gain_req  in  GAIN_W  requested gain; asynchronous to clk (e.g. from switches or a CPU)
or_clr  in  1  clears or_flag (1-cycle pulse)
peak_clr  in  1  clears peak_mag (1-cycle pulse)
adc_clk_p  out  1  equals clk
adc_clk_n  out  1  equals ~clk
gain_out  out  GAIN_W  registered gain driven to the PGA
data_out  out  DATA_W  converted sample
data_valid  out  1  data_out is usable (not in a settle window)
gain_busy  out  1  high while settling
or_flag  out  1  sticky overrange flag
peak_mag  out  DATA_W  unsigned peak |sample| since last clear

Behaviour:
- Reset (async, rst=1):
  - Outputs: gain_out=GAIN_RST, data_out=0, data_valid=0, or_flag=0, peak_mag=0.
  - Internal: both sync stages = GAIN_RST, state=SETTLE, cnt=SETTLE_CYC-1, gain_busy=1.
  - After reset release, the block therefore blanks for SETTLE_CYC cycles.
- Clock outputs: adc_clk_p/adc_clk_n are combinational from clk and are unaffected by rst.
- Sample pipeline (latency 2 clk from adc_data to data_out):
  - Stage 1: s1 <= adc_data; v1 <= ~gain_busy; or1 <= adc_or.
  - Stage 2: data_out <= TWOS_COMP ? {~s1[MSB], s1[MSB-1:0]} : s1; data_valid <= v1.
- Gain synchroniser: gain_req passes through 2 flops (g1, g2). g2 is the only value the FSM uses.
- FSM, states IDLE and SETTLE:
  - Any state, g2 != gain_out: gain_out <= g2, cnt <= SETTLE_CYC-1, state <= SETTLE, gain_busy <= 1. A change during SETTLE restarts the window.
  - SETTLE, no change, cnt != 0: cnt <= cnt-1.
  - SETTLE, no change, cnt == 0: state <= IDLE, gain_busy <= 0.
  - IDLE, no change: hold.
  - Result: gain_busy is high for exactly SETTLE_CYC cycles after the last change.
- gain_out latency: 3 rising edges from a stable gain_req change to gain_out update. gain_busy rises on the same edge.
- cnt width: clog2(SETTLE_CYC)+1.
- Overrange:
  - or_flag <= 1 when or1=1 (stage-2 aligned) or when an out-of-range code is seen (s1 all-ones or all-zeros raw).
  - Otherwise 0 when or_clr=1, else hold.
  - Set and clear in the same cycle: set wins.
- Peak:
  - mag = |converted sample|, computed from the stage-2 value, unsigned DATA_W bits. Most negative code gives 2^(DATA_W-1), with no overflow.
  - When TWOS_COMP=0, mag uses the offset-binary distance from mid-code (same result).
  - Update only when data_valid=1: if mag > peak_mag, then peak_mag <= mag.
  - peak_clr=1: peak_mag <= mag if data_valid, else 0. Clear takes priority over hold; the same-cycle sample is kept.
- No back-pressure: a sample is produced every clk; downstream must accept or drop it.

Test Plan:
- Reset then idle, gain_req=GAIN_RST, SETTLE_CYC=16: data_valid=0 for the first 16+2 cycles after rst falls, then stays 1; gain_busy=0 from cycle 16.
- adc_data=12'h800 then 12'h7FF then 12'h000, TWOS_COMP=1: data_out = 12'h000, 12'hFFF, 12'h800, each 2 cycles after input; peak_mag = 12'h800 at the end.
- gain_req 0->5 held (IDLE): gain_out=5 on the 3rd edge; gain_busy high exactly 16 cycles; data_valid low over the corresponding 16 aligned samples.
- gain_req 5->7 at 8 cycles into SETTLE: gain_out=7, window restarts, total busy = 8+16 cycles.
- Overrange and flag clear:
  - adc_or=1 for 1 cycle: or_flag=1 two cycles later and stays 1.
  - or_clr pulse with adc_or=0: or_flag=0.
  - or_clr coincident with a new overrange: or_flag stays 1.
- peak_clr during SETTLE: peak_mag=0. Assert rst mid-SETTLE: all outputs return immediately to reset values, gain_out=GAIN_RST.
